// File: rtl/aximm_follower_burst_mem.sv
// AXI4-MM follower backed by an inferred word-wide memory.
// Independent read and write engines; FIXED/INCR/WRAP bursts; byte-strobed writes.
module aximm_follower_burst_mem #(
    parameter int DWIDTH    = 128,
    parameter int ADDRWIDTH = 32,
    parameter int IDWIDTH   = 4,
    parameter int MEM_AW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IDWIDTH-1:0]     F_user_awid,
    input  logic [ADDRWIDTH-1:0]   F_user_awaddr,
    input  logic [7:0]             F_user_awlen,
    input  logic [2:0]             F_user_awsize,
    input  logic [1:0]             F_user_awburst,
    input  logic                   F_user_awvalid,
    output logic                   F_user_awready,
    input  logic [DWIDTH-1:0]      user_wdata,
    input  logic [DWIDTH/8-1:0]    user_wstrb,
    input  logic                   user_wlast,
    input  logic                   user_wvalid,
    output logic                   user_wready,
    output logic [IDWIDTH-1:0]     F_user_bid,
    output logic [1:0]             F_user_bresp,
    output logic                   F_user_bvalid,
    input  logic                   F_user_bready,
    input  logic [IDWIDTH-1:0]     F_user_arid,
    input  logic [ADDRWIDTH-1:0]   F_user_araddr,
    input  logic [7:0]             F_user_arlen,
    input  logic [2:0]             F_user_arsize,
    input  logic [1:0]             F_user_arburst,
    input  logic                   F_user_arvalid,
    output logic                   F_user_arready,
    output logic [IDWIDTH-1:0]     F_user_rid,
    output logic [DWIDTH-1:0]      F_user_rdata,
    output logic [1:0]             F_user_rresp,
    output logic                   F_user_rlast,
    output logic                   F_user_rvalid,
    input  logic                   F_user_rready,
    output logic                   write_complete,
    output logic                   read_complete
);
    localparam int OFS = $clog2(DWIDTH / 8);
    localparam int NB  = DWIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic [MEM_AW-1:0] next_word(input logic [MEM_AW-1:0] word,
                                                   input logic [7:0] len,
                                                   input logic [1:0] burst);
        logic [MEM_AW-1:0] mask;
        logic [MEM_AW-1:0] nw;
        mask = MEM_AW'(len);
        case (burst)
            BURST_FIXED: nw = word;
            BURST_WRAP:  nw = (word & ~mask) | ((word + 1'b1) & mask);
            default:     nw = word + 1'b1;
        endcase
        return nw;
    endfunction

    function automatic logic burst_err(input logic [ADDRWIDTH-1:0] addr,
                                       input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic e;
        e = 1'b0;
        if ((addr >> (MEM_AW + OFS)) != '0) e = 1'b1;
        if (burst == 2'b11) e = 1'b1;
        if (size != 3'(OFS)) e = 1'b1;
        if (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            e = 1'b1;
        return e;
    endfunction

    logic [DWIDTH-1:0] mem [0:(2**MEM_AW)-1];

    // ---------------- write engine ----------------
    wstate_t             wstate_q;
    logic                awready_q, wready_q, bvalid_q, write_complete_q;
    logic [IDWIDTH-1:0]  bid_q;
    logic [1:0]          bresp_q;
    logic [MEM_AW-1:0]   wword_q;
    logic [7:0]          wlen_q, wcnt_q;
    logic [1:0]          wburst_q;
    logic                werr_q;

    logic [MEM_AW-1:0]   aw_word;
    logic                aw_err;
    logic                wbeat;
    logic                wr_en;

    assign aw_word = F_user_awaddr[MEM_AW+OFS-1:OFS];
    assign aw_err  = burst_err(F_user_awaddr, F_user_awlen, F_user_awsize, F_user_awburst);
    assign wbeat   = (wstate_q == W_DATA) && user_wvalid && wready_q;
    // werr_q covers both a bad burst and beats past the final one without wlast.
    assign wr_en   = wbeat && !werr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate_q         <= W_IDLE;
            awready_q        <= 1'b1;
            wready_q         <= 1'b0;
            bvalid_q         <= 1'b0;
            write_complete_q <= 1'b0;
            bid_q            <= '0;
            bresp_q          <= RESP_OKAY;
            wword_q          <= '0;
            wlen_q           <= '0;
            wcnt_q           <= '0;
            wburst_q         <= '0;
            werr_q           <= 1'b0;
        end else begin
            write_complete_q <= 1'b0;
            case (wstate_q)
                W_IDLE: begin
                    if (F_user_awvalid) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= F_user_awid;
                        wword_q   <= aw_word;
                        wlen_q    <= F_user_awlen;
                        wburst_q  <= F_user_awburst;
                        werr_q    <= aw_err;
                        wcnt_q    <= '0;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wbeat) begin
                        wword_q <= next_word(wword_q, wlen_q, wburst_q);
                        if (wcnt_q != wlen_q) wcnt_q <= wcnt_q + 8'd1;
                        if (user_wlast) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (werr_q || wcnt_q != wlen_q) ? RESP_SLVERR : RESP_OKAY;
                            wstate_q <= W_RESP;
                        end else if (wcnt_q == wlen_q) begin
                            werr_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (F_user_bready) begin
                        bvalid_q         <= 1'b0;
                        write_complete_q <= 1'b1;
                        awready_q        <= 1'b1;
                        wstate_q         <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (user_wstrb[b]) mem[wword_q][b*8 +: 8] <= user_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    rstate_t             rstate_q;
    logic                arready_q, rvalid_q, rlast_q, read_complete_q;
    logic [IDWIDTH-1:0]  rid_q;
    logic [DWIDTH-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic [MEM_AW-1:0]   rnext_q;
    logic [7:0]          rlen_q, rcnt_q;
    logic [1:0]          rburst_q;
    logic                rerr_q;

    logic [MEM_AW-1:0]   ar_word;
    logic                ar_err;

    assign ar_word = F_user_araddr[MEM_AW+OFS-1:OFS];
    assign ar_err  = burst_err(F_user_araddr, F_user_arlen, F_user_arsize, F_user_arburst);

    // rdata only loads on AR or a beat handshake, so a stalled beat never sees later writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate_q        <= R_IDLE;
            arready_q       <= 1'b1;
            rvalid_q        <= 1'b0;
            rlast_q         <= 1'b0;
            read_complete_q <= 1'b0;
            rid_q           <= '0;
            rdata_q         <= '0;
            rresp_q         <= RESP_OKAY;
            rnext_q         <= '0;
            rlen_q          <= '0;
            rcnt_q          <= '0;
            rburst_q        <= '0;
            rerr_q          <= 1'b0;
        end else begin
            read_complete_q <= 1'b0;
            case (rstate_q)
                R_IDLE: begin
                    if (F_user_arvalid) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= F_user_arid;
                        rresp_q   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_q   <= (F_user_arlen == 8'd0);
                        rcnt_q    <= '0;
                        rlen_q    <= F_user_arlen;
                        rburst_q  <= F_user_arburst;
                        rerr_q    <= ar_err;
                        rdata_q   <= ar_err ? '0 : mem[ar_word];
                        rnext_q   <= next_word(ar_word, F_user_arlen, F_user_arburst);
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (F_user_rready) begin
                        if (rlast_q) begin
                            rvalid_q        <= 1'b0;
                            rlast_q         <= 1'b0;
                            read_complete_q <= 1'b1;
                            arready_q       <= 1'b1;
                            rstate_q        <= R_IDLE;
                        end else begin
                            rcnt_q  <= rcnt_q + 8'd1;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                            rdata_q <= rerr_q ? '0 : mem[rnext_q];
                            rnext_q <= next_word(rnext_q, rlen_q, rburst_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign F_user_awready = awready_q;
    assign user_wready    = wready_q;
    assign F_user_bid     = bid_q;
    assign F_user_bresp   = bresp_q;
    assign F_user_bvalid  = bvalid_q;
    assign write_complete = write_complete_q;
    assign F_user_arready = arready_q;
    assign F_user_rid     = rid_q;
    assign F_user_rdata   = rdata_q;
    assign F_user_rresp   = rresp_q;
    assign F_user_rlast   = rlast_q;
    assign F_user_rvalid  = rvalid_q;
    assign read_complete  = read_complete_q;

endmodule
